// File: rtl/isa_dma_responder.sv
// isa_dma_responder: 8-bit ISA DMA slave endpoint with local byte FIFO and valid/ready stream ports.
// Define ISA_DMA_WAIT_EN to stretch each strobe with WAIT_STATES clocks of io_channel_ready low.
module isa_dma_responder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       dir,
  output logic       dma_request,
  input  logic       dma_acknowledge_n,
  input  logic       io_read_n,
  input  logic       io_write_n,
  input  logic       terminal_count_n,
  input  logic [7:0] data_bus_in,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_en,
  output logic       io_channel_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       tc_flag,
  output logic       tc_pulse,
  output logic       overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_ACK = 3'd2, ST_STROBE = 3'd3, ST_END = 3'd4;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must be 1..15");
  end

  logic [2:0] state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] head_q, head_d, bus_data_q, bus_data_d, wr_data;
  logic tc_seen_q, tc_seen_d, tc_flag_q, tc_flag_d, tc_pulse_q, tc_pulse_d, overrun_q, overrun_d;
  logic strobe_lo, strobing, commit, full, req_cond, push, pop, tc_hit;

  always_comb begin
    strobe_lo = dir ? !io_write_n : !io_read_n;
    strobing = !dma_acknowledge_n && strobe_lo && (state_q == ST_ACK || state_q == ST_STROBE);
    commit = state_q == ST_STROBE && !strobe_lo;
    full = count_q == (AW+1)'(FIFO_DEPTH);
    req_cond = enable && !tc_flag_q && (dir ? !full : count_q != '0);
    push = dir ? commit && !full : in_valid && !full;
    pop = dir ? out_ready && count_q != '0 : commit && count_q != '0;
    wr_data = dir ? bus_data_q : in_data;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    head_d = count_q != '0 ? mem_q[rd_ptr_q] : head_q;
    bus_data_d = strobing && dir ? data_bus_in : bus_data_q;
    tc_seen_d = (state_q == ST_ACK || state_q == ST_STROBE) ? tc_seen_q || (strobing && !terminal_count_n) : 1'b0;
    tc_hit = commit && (tc_seen_q || !terminal_count_n);
    tc_flag_d = enable && (tc_flag_q || tc_hit);
    tc_pulse_d = enable && tc_hit;
    overrun_d = overrun_q || (commit && dir && full);
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_REQ: state_d = !dma_acknowledge_n ? ST_ACK : req_cond ? ST_REQ : ST_IDLE;
      ST_ACK: state_d = dma_acknowledge_n ? ST_IDLE : strobe_lo ? ST_STROBE : ST_ACK;
      ST_STROBE: state_d = strobe_lo ? ST_STROBE : ST_END;
      ST_END: state_d = !dma_acknowledge_n ? ST_END : req_cond ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      head_q <= '0;
      bus_data_q <= '0;
      tc_seen_q <= 1'b0;
      tc_flag_q <= 1'b0;
      tc_pulse_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      head_q <= head_d;
      bus_data_q <= bus_data_d;
      tc_seen_q <= tc_seen_d;
      tc_flag_q <= tc_flag_d;
      tc_pulse_q <= tc_pulse_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef ISA_DMA_WAIT_EN
  logic [3:0] wait_q, wait_d;
  always_comb begin
    wait_d = state_d != ST_STROBE ? 4'd0 : state_q != ST_STROBE ? 4'(WAIT_STATES) : wait_q - 4'(wait_q != 4'd0);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_q <= 4'd0;
    else wait_q <= wait_d;
  end
  // A strobe released early frees the bus at once rather than at the counter's end
  assign io_channel_ready = wait_q == 4'd0 || !strobe_lo;
`else
  assign io_channel_ready = 1'b1;
`endif

  assign dma_request = state_q == ST_REQ;
  assign data_bus_out = head_q;
  assign data_bus_out_en = !reset && !dma_acknowledge_n && !io_read_n && !dir;
  assign in_ready = !full;
  assign out_valid = count_q != '0;
  assign out_data = mem_q[rd_ptr_q];
  assign tc_flag = tc_flag_q;
  assign tc_pulse = tc_pulse_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_isa_dma_responder.sv
// tb_isa_dma_responder: directed checks of the ISA DMA responder in both directions, TC, wait states and reset.
module tb_isa_dma_responder;
`ifdef ISA_DMA_WAIT_EN
  localparam bit WAIT_ON = 1'b1;
`else
  localparam bit WAIT_ON = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, enable = 1'b0, dir = 1'b0;
  logic dma_request, dma_acknowledge_n = 1'b1, io_read_n = 1'b1, io_write_n = 1'b1, terminal_count_n = 1'b1;
  logic [7:0] data_bus_in = '0, data_bus_out, in_data = '0, out_data;
  logic data_bus_out_en, io_channel_ready, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic tc_flag, tc_pulse, overrun;
  int vectors = 0, miscompares = 0;

  isa_dma_responder #(.FIFO_DEPTH(16), .WAIT_STATES(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .dir(dir), .dma_request(dma_request),
    .dma_acknowledge_n(dma_acknowledge_n), .io_read_n(io_read_n), .io_write_n(io_write_n),
    .terminal_count_n(terminal_count_n), .data_bus_in(data_bus_in), .data_bus_out(data_bus_out),
    .data_bus_out_en(data_bus_out_en), .io_channel_ready(io_channel_ready), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .tc_flag(tc_flag), .tc_pulse(tc_pulse), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic setup(input logic d);
    enable = 1'b0; reset = 1'b1; dma_acknowledge_n = 1'b1; io_read_n = 1'b1; io_write_n = 1'b1;
    terminal_count_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dir = d;
    tick;
    reset = 1'b0;
    tick;
    enable = 1'b1;
  endtask

  task automatic push_bytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = first + 8'(i);
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] exp, input logic tc, input logic psh, input logic [7:0] pd);
    dma_acknowledge_n = 1'b0;
    tick;
    vectors++; if (dma_request !== 1'b0) begin miscompares++; $display("FAIL dreq_after_dack: got %b expected 0", dma_request); end
    io_read_n = 1'b0; terminal_count_n = !tc;
    #1;
    vectors++; if (data_bus_out_en !== 1'b1) begin miscompares++; $display("FAIL out_en_ior: got %b expected 1", data_bus_out_en); end
    vectors++; if (data_bus_out !== exp) begin miscompares++; $display("FAIL read_data: got %h expected %h", data_bus_out, exp); end
    tick;
    tick;
    io_read_n = 1'b1; terminal_count_n = 1'b1; in_valid = psh; in_data = pd;
    #1;
    vectors++; if (data_bus_out_en !== 1'b0) begin miscompares++; $display("FAIL out_en_idle: got %b expected 0", data_bus_out_en); end
    tick;
    in_valid = 1'b0;
    vectors++; if (tc_pulse !== tc) begin miscompares++; $display("FAIL tc_pulse_commit: got %b expected %b", tc_pulse, tc); end
    dma_acknowledge_n = 1'b1;
    tick;
    vectors++; if (tc_pulse !== 1'b0) begin miscompares++; $display("FAIL tc_pulse_width: got %b expected 0", tc_pulse); end
  endtask

  task automatic bus_write(input logic [7:0] d);
    dma_acknowledge_n = 1'b0;
    tick;
    io_write_n = 1'b0; data_bus_in = d;
    tick;
    tick;
    io_write_n = 1'b1; data_bus_in = 8'h00;
    tick;
    dma_acknowledge_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    tick;
    vectors++; if ({dma_request, data_bus_out, data_bus_out_en, tc_flag, tc_pulse, overrun, out_valid} !== 14'd0) begin
      miscompares++; $display("FAIL reset_zero_outputs: got %h expected 0", {dma_request, data_bus_out, data_bus_out_en, tc_flag, tc_pulse, overrun, out_valid});
    end
    vectors++; if ({io_channel_ready, in_ready} !== 2'b11) begin miscompares++; $display("FAIL reset_ready: got %b expected 11", {io_channel_ready, in_ready}); end
  endtask

  task automatic test_dev_to_mem;
    setup(1'b0);
    in_valid = 1'b1; in_data = 8'hA5;
    tick;
    vectors++; if (dma_request !== 1'b0) begin miscompares++; $display("FAIL dreq_early: got %b expected 0", dma_request); end
    in_data = 8'h3C;
    tick;
    in_valid = 1'b0;
    vectors++; if (dma_request !== 1'b1) begin miscompares++; $display("FAIL dreq_rise: got %b expected 1", dma_request); end
    bus_read(8'hA5, 1'b0, 1'b0, 8'h00);
    bus_read(8'h3C, 1'b0, 1'b0, 8'h00);
    vectors++; if (dma_request !== 1'b0) begin miscompares++; $display("FAIL dreq_empty: got %b expected 0", dma_request); end
    tick;
    vectors++; if ({dma_request, out_valid} !== 2'b00) begin miscompares++; $display("FAIL stay_empty: got %b expected 00", {dma_request, out_valid}); end
  endtask

  task automatic test_mem_to_dev;
    setup(1'b1);
    tick;
    vectors++; if (dma_request !== 1'b1) begin miscompares++; $display("FAIL dreq_dir1: got %b expected 1", dma_request); end
    for (int i = 0; i < 16; i++) bus_write(8'(i));
    vectors++; if ({dma_request, in_ready, overrun} !== 3'b000) begin miscompares++; $display("FAIL full_state: got %b expected 000", {dma_request, in_ready, overrun}); end
    bus_write(8'hFF);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun: got %b expected 1", overrun); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vectors++; if ({out_valid, out_data} !== {1'b1, 8'(i)}) begin miscompares++; $display("FAIL drain[%0d]: got %b/%h expected 1/%h", i, out_valid, out_data, 8'(i)); end
      tick;
    end
    out_ready = 1'b0;
    vectors++; if ({out_valid, overrun} !== 2'b01) begin miscompares++; $display("FAIL drained: got %b expected 01", {out_valid, overrun}); end
  endtask

  task automatic test_tc;
    setup(1'b0);
    push_bytes(8'h10, 4);
    tick;
    bus_read(8'h10, 1'b0, 1'b0, 8'h00);
    bus_read(8'h11, 1'b0, 1'b0, 8'h00);
    bus_read(8'h12, 1'b1, 1'b0, 8'h00);
    vectors++; if (tc_flag !== 1'b1) begin miscompares++; $display("FAIL tc_flag_set: got %b expected 1", tc_flag); end
    tick;
    tick;
    vectors++; if (dma_request !== 1'b0) begin miscompares++; $display("FAIL dreq_after_tc: got %b expected 0", dma_request); end
    enable = 1'b0;
    tick;
    vectors++; if (tc_flag !== 1'b0) begin miscompares++; $display("FAIL tc_flag_clear: got %b expected 0", tc_flag); end
    enable = 1'b1;
    tick;
    vectors++; if (dma_request !== 1'b1) begin miscompares++; $display("FAIL rearm: got %b expected 1", dma_request); end
    bus_read(8'h13, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_wait;
    setup(1'b0);
    push_bytes(8'h40, 1);
    tick;
    dma_acknowledge_n = 1'b0;
    tick;
    io_read_n = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (io_channel_ready !== !(WAIT_ON && k < 3)) begin
        miscompares++; $display("FAIL wait_ready[%0d]: got %b expected %b", k, io_channel_ready, !(WAIT_ON && k < 3));
      end
      tick;
    end
    io_read_n = 1'b1;
    tick;
    dma_acknowledge_n = 1'b1;
    tick;
    vectors++; if ({io_channel_ready, out_valid} !== 2'b10) begin miscompares++; $display("FAIL wait_done: got %b expected 10", {io_channel_ready, out_valid}); end
  endtask

  task automatic test_simultaneous;
    setup(1'b0);
    push_bytes(8'h20, 5);
    tick;
    io_read_n = 1'b0;
    #1;
    vectors++; if (data_bus_out_en !== 1'b0) begin miscompares++; $display("FAIL ior_no_dack_en: got %b expected 0", data_bus_out_en); end
    tick;
    tick;
    io_read_n = 1'b1;
    tick;
    bus_read(8'h20, 1'b0, 1'b1, 8'h25);
    for (int i = 1; i < 6; i++) bus_read(8'h20 + 8'(i), 1'b0, 1'b0, 8'h00);
    vectors++; if ({dma_request, out_valid} !== 2'b00) begin miscompares++; $display("FAIL count_kept: got %b expected 00", {dma_request, out_valid}); end
  endtask

  task automatic test_reset_mid;
    setup(1'b0);
    push_bytes(8'h30, 2);
    tick;
    dma_acknowledge_n = 1'b0;
    tick;
    io_read_n = 1'b0;
    tick;
    #2 reset = 1'b1;
    #1;
    vectors++; if ({dma_request, data_bus_out, data_bus_out_en, tc_flag, tc_pulse, overrun, out_valid} !== 14'd0) begin
      miscompares++; $display("FAIL async_reset_zero: got %h expected 0", {dma_request, data_bus_out, data_bus_out_en, tc_flag, tc_pulse, overrun, out_valid});
    end
    vectors++; if ({io_channel_ready, in_ready} !== 2'b11) begin miscompares++; $display("FAIL async_reset_ready: got %b expected 11", {io_channel_ready, in_ready}); end
    io_read_n = 1'b1; dma_acknowledge_n = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    tick;
    vectors++; if ({dma_request, out_valid, data_bus_out} !== 10'd0) begin miscompares++; $display("FAIL post_reset: got %h expected 0", {dma_request, out_valid, data_bus_out}); end
  endtask

  initial begin
    test_reset;
    test_dev_to_mem;
    test_mem_to_dev;
    test_tc;
    test_wait;
    test_simultaneous;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
